pipelined_shifter: RTL and testbench

Parametrised, two-stage pipelined barrel shifter supporting logical left, logical right, arithmetic right and rotate-right, with valid/ready handshakes on both sides. It is the successor to the fixed 32-bit combinational left shifter. It sits between the ALU operand registers and the writeback mux, where a registered, back-pressurable shift unit is required.

---
 rtl/shifter_pkg.sv | 11 +
 rtl/shift_level.sv | 25 ++
 rtl/pipelined_shifter.sv | 90 +++++++++
 tb/tb_pipelined_shifter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
package shifter_pkg;
    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        ROR = 2'b10,
        SRA = 2'b11
    } shift_op_t;

    localparam int SHIFTER_LATENCY = 2;
endpackage

// File: rtl/shift_level.sv
// One level of the log shifter: conditionally shifts/rotates by the fixed amount AMT.
module shift_level
    import shifter_pkg::*;
#(
    parameter int N   = 32,
    parameter int AMT = 1
) (
    input  logic [N-1:0] i_data,
    input  shift_op_t    i_op,
    input  logic         i_fill,
    input  logic         i_en,
    output logic [N-1:0] o_data
);
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SLL: o_data = {i_data[N-AMT-1:0], {AMT{1'b0}}};
                SRL: o_data = {{AMT{1'b0}}, i_data[N-1:AMT]};
                SRA: o_data = {{AMT{i_fill}}, i_data[N-1:AMT]};
                ROR: o_data = {i_data[AMT-1:0], i_data[N-1:AMT]};
            endcase
        end
    end
endmodule

// File: rtl/pipelined_shifter.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] in_shamt,
    input  shift_op_t    in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);
    localparam int K  = (L + 1) / 2;
    localparam int L2 = L - K;

    logic            r_s1_valid;
    logic [N-1:0]    r_s1_data;
    shift_op_t       r_s1_op;
    logic [L2-1:0]   r_s1_shamt;
    logic            r_s1_sign;
    logic            r_s2_valid;
    logic [N-1:0]    r_s2_data;

    logic            w_s1_load;
    logic            w_s2_load;
    logic [L-1:0]    w_en;
    logic [N-1:0]    w_lvl_in  [L];
    logic [N-1:0]    w_lvl_out [L];

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;

    // Low levels take their enables from the live request, high levels from the s1 register.
    assign w_en = {r_s1_shamt, in_shamt[K-1:0]};

    for (genvar k = 0; k < L; k++) begin : g_lvl
        if (k == 0) begin : g_src_in
            assign w_lvl_in[k] = in_data;
        end else if (k == K) begin : g_src_s1
            assign w_lvl_in[k] = r_s1_data;
        end else begin : g_src_chain
            assign w_lvl_in[k] = w_lvl_out[k-1];
        end

        shift_level #(.N(N), .AMT(1 << k)) u_level (
            .i_data (w_lvl_in[k]),
            .i_op   ((k < K) ? in_op : r_s1_op),
            .i_fill ((k < K) ? in_data[N-1] : r_s1_sign),
            .i_en   (w_en[k]),
            .o_data (w_lvl_out[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_op    <= SLL;
            r_s1_shamt <= '0;
            r_s1_sign  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data  <= w_lvl_out[K-1];
                    r_s1_op    <= in_op;
                    r_s1_shamt <= in_shamt[L-1:K];
                    r_s1_sign  <= in_data[N-1];
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_lvl_out[L-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: random traffic against a queue-based reference model plus directed literals.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    localparam int N = 32;
    localparam int L = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [L-1:0] in_shamt;
    shift_op_t    in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] q[$];
    logic         prev_stall;
    logic [N-1:0] prev_data;

    pipelined_shifter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_shift(shift_op_t op, logic [N-1:0] d, logic [L-1:0] s);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   r;
        dbl = {d, d} >> s;
        case (op)
            SLL: r = d << s;
            SRL: r = d >> s;
            SRA: r = $signed(d) >>> s;
            default: r = dbl[N-1:0];
        endcase
        return r;
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare process: every cycle, check ready, hold-stability and output data against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check(in_ready == !(q.size() == 2 && !out_ready), "in_ready", 64'(in_ready),
                  64'(!(q.size() == 2 && !out_ready)));
            if (prev_stall)
                check(out_valid && out_data == prev_data, "hold_stable", 64'(out_data), 64'(prev_data));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_output", 64'(out_data), 64'd0);
                end else begin
                    check(out_data == q[0], "out_data", 64'(out_data), 64'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) q.push_back(ref_shift(in_op, in_data, in_shamt));
        end
    end

    task automatic send(input shift_op_t op, input logic [N-1:0] d, input logic [L-1:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check(1'b0, "send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input shift_op_t op, input logic [N-1:0] d, input logic [L-1:0] s,
                            input logic [N-1:0] exp, input string name);
        send(op, d, s);
        check(!out_valid, {name, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check(out_valid == 1'b1, {name, "_valid"}, 64'(out_valid), 64'd1);
        check(out_data == exp, name, 64'(out_data), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] rnd;
        int          sent;
        bit          acc;
        bit          pat [3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = SLL;
        out_ready = 1'b1;
        #12;
        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(out_data == '0, "rst_out_data", 64'(out_data), 64'd0);
        check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "idle_out_valid", 64'(out_valid), 64'd0);

        directed(SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_31");
        directed(SLL, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, "sll_0");
        directed(SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, "srl_4");
        directed(SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, "sra_neg");
        directed(SRA, 32'h7000_0000, 5'd4,  32'h0700_0000, "sra_pos");
        directed(ROR, 32'h0000_00F1, 5'd4,  32'h1000_000F, "ror_4");
        directed(ROR, 32'h1234_5678, 5'd16, 32'h5678_1234, "ror_16");
        directed(SRA, 32'h8765_4321, 5'd0,  32'h8765_4321, "sra_0");

        // Back-to-back 8 requests with out_ready pattern 1,0,0 repeating.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        sent = 0;
        for (int c = 0; c < 80 && sent < 8; c++) begin
            out_ready = pat[c % 3];
            in_valid  = 1'b1;
            in_op     = shift_op_t'(sent % 4);
            in_data   = 32'h1111_1111 * (sent + 1) ^ 32'h8000_0000;
            in_shamt  = L'(sent * 3 + 1);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check(sent == 8, "b2b_sent", 64'(sent), 64'd8);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 800; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = shift_op_t'($urandom_range(0, 3));
            rnd       = {$urandom(), $urandom()};
            in_data   = rnd[N-1:0];
            in_shamt  = L'($urandom_range(0, N - 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check(q.size() == 0, "drain_empty", 64'(q.size()), 64'd0);

        // Reset with two results in flight.
        out_ready = 1'b0;
        send(SLL, 32'h0000_00AA, 5'd1);
        send(SRL, 32'h0000_0BB0, 5'd4);
        check(out_valid == 1'b1, "pre_rst_valid", 64'(out_valid), 64'd1);
        check(in_ready == 1'b0, "pre_rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "rst_flush_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check(out_valid == 1'b0, "post_rst_stale", 64'(out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
